// File: rtl/video_timing_gen_if.sv
// Bundle between the timing generator and its user: runtime mode/ROI programming in,
// sync, data-enable, coordinates and strobes out.
interface video_timing_gen_if #(
  parameter int CNT_W = 12
) ();
  logic [CNT_W-1:0] cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp;
  logic [CNT_W-1:0] cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp;
  logic [CNT_W-1:0] cfg_win_x0, cfg_win_y0, cfg_win_w, cfg_win_h;
  logic             cfg_load;
  logic             cfg_pending;
  logic             hs, vs, de;
  logic [CNT_W-1:0] active_x, active_y;
  logic             sof, eol, win;

  modport master (
    output cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
    output cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp,
    output cfg_win_x0, cfg_win_y0, cfg_win_w, cfg_win_h, cfg_load,
    input  cfg_pending, hs, vs, de, active_x, active_y, sof, eol, win
  );

  modport slave (
    input  cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
    input  cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp,
    input  cfg_win_x0, cfg_win_y0, cfg_win_w, cfg_win_h, cfg_load,
    output cfg_pending, hs, vs, de, active_x, active_y, sof, eol, win
  );
endinterface

// File: rtl/video_timing_gen.sv
// Runtime-reprogrammable video timing generator: pending mode/ROI set is swapped into the
// active set only on the last pixel of a frame, so a new mode always starts cleanly at sof.
module video_timing_gen #(
  parameter int CNT_W    = 12,
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int WIN_X0   = 0,
  parameter int WIN_Y0   = 0,
  parameter int WIN_W    = 480,
  parameter int WIN_H    = 272
) (
  input logic              clk,
  input logic              rst,
  video_timing_gen_if.slave vt
);
  localparam int NF = 12;
  localparam int EW = CNT_W + 2;
  localparam int F_HA = 0, F_HF = 1, F_HS = 2, F_HB = 3;
  localparam int F_VA = 4, F_VF = 5, F_VS = 6, F_VB = 7;
  localparam int F_X0 = 8, F_Y0 = 9, F_WW = 10, F_WH = 11;

  localparam logic [CNT_W-1:0] RST_CFG [NF] = '{
    CNT_W'(H_ACTIVE), CNT_W'(H_FP), CNT_W'(H_SYNC), CNT_W'(H_BP),
    CNT_W'(V_ACTIVE), CNT_W'(V_FP), CNT_W'(V_SYNC), CNT_W'(V_BP),
    CNT_W'(WIN_X0),   CNT_W'(WIN_Y0), CNT_W'(WIN_W), CNT_W'(WIN_H)
  };

  logic [CNT_W-1:0] w_cfg_in [NF];
  logic [CNT_W-1:0] r_act    [NF];
  logic [CNT_W-1:0] r_pend   [NF];
  logic             r_pending;

  assign w_cfg_in[F_HA] = vt.cfg_h_active;
  assign w_cfg_in[F_HF] = vt.cfg_h_fp;
  assign w_cfg_in[F_HS] = vt.cfg_h_sync;
  assign w_cfg_in[F_HB] = vt.cfg_h_bp;
  assign w_cfg_in[F_VA] = vt.cfg_v_active;
  assign w_cfg_in[F_VF] = vt.cfg_v_fp;
  assign w_cfg_in[F_VS] = vt.cfg_v_sync;
  assign w_cfg_in[F_VB] = vt.cfg_v_bp;
  assign w_cfg_in[F_X0] = vt.cfg_win_x0;
  assign w_cfg_in[F_Y0] = vt.cfg_win_y0;
  assign w_cfg_in[F_WW] = vt.cfg_win_w;
  assign w_cfg_in[F_WH] = vt.cfg_win_h;

  logic [CNT_W-1:0] r_h_cnt, r_v_cnt;

  // Extended-width boundaries so sums never wrap for totals up to 2^CNT_W.
  logic [EW-1:0]    w_h_start, w_h_stop, w_h_last, w_v_start, w_v_stop, w_v_last;
  logic [EW-1:0]    w_h_cnt_e, w_v_cnt_e, w_x_full, w_y_full, w_x_e, w_y_e;
  logic             w_h_end, w_v_end, w_apply, w_h_in, w_v_in, w_de, w_in_roi;
  logic [CNT_W-1:0] w_x, w_y;

  assign w_h_cnt_e = EW'(r_h_cnt);
  assign w_v_cnt_e = EW'(r_v_cnt);
  assign w_h_start = EW'(r_act[F_HS]) + EW'(r_act[F_HB]);
  assign w_h_stop  = w_h_start + EW'(r_act[F_HA]);
  assign w_h_last  = w_h_stop + EW'(r_act[F_HF]) - EW'(1);
  assign w_v_start = EW'(r_act[F_VS]) + EW'(r_act[F_VB]);
  assign w_v_stop  = w_v_start + EW'(r_act[F_VA]);
  assign w_v_last  = w_v_stop + EW'(r_act[F_VF]) - EW'(1);

  assign w_h_end = (w_h_cnt_e == w_h_last);
  assign w_v_end = (w_v_cnt_e == w_v_last);
  assign w_apply = w_h_end && w_v_end;

  assign w_h_in = (w_h_cnt_e >= w_h_start) && (w_h_cnt_e < w_h_stop);
  assign w_v_in = (w_v_cnt_e >= w_v_start) && (w_v_cnt_e < w_v_stop);
  assign w_de   = w_h_in && w_v_in;

  assign w_x_full = w_h_cnt_e - w_h_start;
  assign w_y_full = w_v_cnt_e - w_v_start;
  assign w_x      = w_x_full[CNT_W-1:0];
  assign w_y      = w_y_full[CNT_W-1:0];
  assign w_x_e    = EW'(w_x);
  assign w_y_e    = EW'(w_y);

  // A zero width or height makes the upper bound equal the lower one, so the ROI is empty.
  assign w_in_roi = (w_x_e >= EW'(r_act[F_X0])) && (w_x_e < EW'(r_act[F_X0]) + EW'(r_act[F_WW])) &&
                    (w_y_e >= EW'(r_act[F_Y0])) && (w_y_e < EW'(r_act[F_Y0]) + EW'(r_act[F_WH]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NF; i++) begin
        r_act[i]  <= RST_CFG[i];
        r_pend[i] <= '0;
      end
      r_pending <= 1'b0;
    end else begin
      if (vt.cfg_load) begin
        for (int i = 0; i < NF; i++) r_pend[i] <= w_cfg_in[i];
      end
      // A load landing on the apply cycle bypasses the pending set entirely.
      if (w_apply) begin
        if (vt.cfg_load) begin
          for (int i = 0; i < NF; i++) r_act[i] <= w_cfg_in[i];
        end else if (r_pending) begin
          for (int i = 0; i < NF; i++) r_act[i] <= r_pend[i];
        end
        r_pending <= 1'b0;
      end else if (vt.cfg_load) begin
        r_pending <= 1'b1;
      end
    end
  end

  logic             r_hs, r_vs, r_de, r_sof, r_eol, r_win;
  logic [CNT_W-1:0] r_x, r_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_hs    <= ~HS_POL;
      r_vs    <= ~VS_POL;
      r_de    <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_sof   <= 1'b0;
      r_eol   <= 1'b0;
      r_win   <= 1'b0;
    end else begin
      if (w_h_end) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_end ? '0 : r_v_cnt + CNT_W'(1);
      end else begin
        r_h_cnt <= r_h_cnt + CNT_W'(1);
      end
      r_hs  <= (r_h_cnt < r_act[F_HS]) ? HS_POL : ~HS_POL;
      r_vs  <= (r_v_cnt < r_act[F_VS]) ? VS_POL : ~VS_POL;
      r_de  <= w_de;
      r_x   <= w_de ? w_x : '0;
      r_y   <= w_de ? w_y : '0;
      r_sof <= (r_h_cnt == '0) && (r_v_cnt == '0);
      r_eol <= w_de && (w_x == r_act[F_HA] - CNT_W'(1));
      r_win <= w_de && w_in_roi;
    end
  end

  assign vt.cfg_pending = r_pending;
  assign vt.hs          = r_hs;
  assign vt.vs          = r_vs;
  assign vt.de          = r_de;
  assign vt.active_x    = r_x;
  assign vt.active_y    = r_y;
  assign vt.sof         = r_sof;
  assign vt.eol         = r_eol;
  assign vt.win         = r_win;
endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised, runtime-reprogrammable video timing generator; successor to the fixed-mode 720p timing block. Produces hs/vs/de, pixel coordinates, frame and line strobes, and a programmable region-of-interest flag for the pixel pipeline and LUT-network input window. Timing registers are shadowed and swapped only at frame boundaries, so mode changes never produce a torn frame. Sits directly on the pixel clock, feeding the HDMI/TMDS encoder and the frame-capture logic.

## Interface
- CNT_W, 12, width of all counters, coordinates and config fields
- H_ACTIVE / H_FP / H_SYNC / H_BP, 1280 / 110 / 40 / 220, reset-time horizontal mode
- V_ACTIVE / V_FP / V_SYNC / V_BP, 720 / 5 / 5 / 20, reset-time vertical mode
- HS_POL / VS_POL, 1 / 1, asserted level of hs / vs
- WIN_X0 / WIN_Y0 / WIN_W / WIN_H, 0 / 0 / 480 / 272, reset-time ROI
- clk  in  1  pixel clock; the block's only clock
- rst  in  1  asynchronous, active-high reset
- cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp  in  CNT_W each  horizontal mode
- cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp  in  CNT_W each  vertical mode
- cfg_win_x0, cfg_win_y0, cfg_win_w, cfg_win_h  in  CNT_W each  ROI, active-area coordinates
- cfg_load  in  1  one-cycle strobe capturing all cfg_* into the pending set
- cfg_pending  out  1  pending set captured but not yet applied
- hs, vs  out  1  sync outputs, level per HS_POL/VS_POL
- de  out  1  active video
- active_x, active_y  out  CNT_W  pixel coordinates within active area
- sof  out  1  one-cycle pulse, first pixel of frame (h_cnt=0, v_cnt=0)
- eol  out  1  one-cycle pulse, last active pixel of each active line
- win  out  1  de and pixel inside ROI

## Operation
- Line order: SYNC, BP, ACTIVE, FP; frame order likewise in lines. H_TOTAL = sync+bp+active+fp; active starts at h_cnt = sync+bp. Same vertically.
- h_cnt wraps H_TOTAL-1 -> 0; v_cnt increments on that wrap and wraps V_TOTAL-1 -> 0.
- hs = HS_POL while h_cnt < h_sync, else ~HS_POL. vs = VS_POL while v_cnt < v_sync (whole lines), else ~VS_POL.
- de = h_cnt and v_cnt both inside their active ranges.
- active_x = h_cnt - (h_sync+h_bp) and active_y = v_cnt - (v_sync+v_bp) while de; both 0 when de low.
- win = de & x0 <= active_x < x0+w & y0 <= active_y < y0+h; bounds computed in CNT_W+1 bits (no wrap). w=0 or h=0 -> win never asserts.
- Register sets: active (drives counters) and pending. Reset loads parameters into active; pending cleared, cfg_pending=0.
- cfg_load: all 12 cfg_* captured into pending, cfg_pending=1. A later cfg_load before apply overwrites pending.
- Apply point: cycle with h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1 (active set). If cfg_pending, pending -> active on that edge, cfg_pending -> 0; counters wrap to 0 and the new mode begins at sof.
- cfg_load on the apply cycle: the cfg_* values on the inputs are applied directly to active; cfg_pending ends 0.
- Contract: sync >= 1, active >= 1, fp/bp >= 0, totals <= 2^CNT_W; not checked in hardware.

## Timing
- Counters reset to 0. All outputs registered from current (h_cnt, v_cnt): one-cycle latency; outputs for counter state N appear after the edge that advances the counter past N.
- Reset values: hs=~HS_POL, vs=~VS_POL, de=0, win=0, sof=0, eol=0, active_x=active_y=0, cfg_pending=0.
- First edge after reset release: sof=1, hs=HS_POL, vs=VS_POL.
- Reset asserted mid-frame: all outputs and counters to reset values immediately (asynchronous); pending set discarded.
- eol coincides with de on active_x = h_active-1; sof coincides with hs and vs asserted.

## Test plan
- Mode reg H 8/2/3/4 (act/fp/sync/bp, total 17), V 4/1/2/1 (total 8), loaded and applied -> frame period 136 cycles; hs high 3 cycles per 17; vs high 34 cycles; de 8 cycles per line on 4 lines.
- Same mode -> active_x steps 0..7 and eol on x=7 each active line; active_y 0..3; sof exactly once per 136 cycles.
- ROI x0=2,w=3,y0=1,h=2 -> win on x=2..4 in lines y=1..2 only (6 cycles/frame); w=0 -> win never asserts.
- cfg_load mid-frame -> cfg_pending=1, current frame timing unchanged, new timing from next sof, cfg_pending=0 at that sof.
- cfg_load on the apply cycle -> new values take effect at the immediately following sof, cfg_pending stays 0.
- rst pulsed mid-line after cfg_load -> outputs at reset values same cycle, pending dropped; restart resumes in 1280x720 defaults (H_TOTAL 1650, V_TOTAL 750).
